// File: rtl/usequencer.sv
// Microprogram sequencer: holds the control-store address, picks the next microaddress and stalls on main-memory waits.
// Optional ACK timeout with trap to TRAP_ADDR is built when USEQUENCER_TIMEOUT_EN is defined.
module usequencer #(
  parameter int                         DATAWIDTH_MADDR     = 11,
  parameter int                         DATAWIDTH_DECODEROP = 8,
  parameter int                         DATAWIDTH_COND      = 3,
  parameter int                         TIMEOUT_CYCLES      = 255,
  parameter logic [DATAWIDTH_MADDR-1:0] TRAP_ADDR           = 11'h7F0
) (
  input  logic                           USEQUENCER_CLOCK_50,
  input  logic                           USEQUENCER_ResetInLow_In,
  input  logic [DATAWIDTH_COND-1:0]      USEQUENCER_Cond_InBus,
  input  logic [DATAWIDTH_MADDR-1:0]     USEQUENCER_JumpAddr_InBus,
  input  logic [DATAWIDTH_DECODEROP-1:0] USEQUENCER_DecodeOP_InBus,
  input  logic                           USEQUENCER_IR13_In,
  input  logic                           USEQUENCER_FlagNegative_In,
  input  logic                           USEQUENCER_FlagZero_In,
  input  logic                           USEQUENCER_FlagOverflow_In,
  input  logic                           USEQUENCER_FlagCarry_In,
  input  logic                           USEQUENCER_MemReq_In,
  input  logic                           USEQUENCER_ACK_In,
  output logic [DATAWIDTH_MADDR-1:0]     USEQUENCER_MicroAddr_OutBus,
  output logic                           USEQUENCER_Hold_Out,
  output logic                           USEQUENCER_Waiting_Out,
  output logic                           USEQUENCER_Timeout_Out
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                     state, state_nxt;
  logic [DATAWIDTH_MADDR-1:0] addr, addr_nxt;
  logic [DATAWIDTH_MADDR-1:0] addr_inc;
  logic [DATAWIDTH_MADDR-1:0] branch_addr;
  logic                       stall;

  // Handshake: a microword with MemReq is a request; it completes in the cycle ACK is
  // high (possibly the request cycle itself). ACK without an outstanding request is ignored.
  assign stall    = USEQUENCER_MemReq_In & ~USEQUENCER_ACK_In;
  assign addr_inc = addr + DATAWIDTH_MADDR'(1);

  always_comb begin
    branch_addr = addr_inc;
    case (USEQUENCER_Cond_InBus)
      3'd1:    if (USEQUENCER_FlagNegative_In) branch_addr = USEQUENCER_JumpAddr_InBus;
      3'd2:    if (USEQUENCER_FlagZero_In)     branch_addr = USEQUENCER_JumpAddr_InBus;
      3'd3:    if (USEQUENCER_FlagOverflow_In) branch_addr = USEQUENCER_JumpAddr_InBus;
      3'd4:    if (USEQUENCER_FlagCarry_In)    branch_addr = USEQUENCER_JumpAddr_InBus;
      3'd5:    if (USEQUENCER_IR13_In)         branch_addr = USEQUENCER_JumpAddr_InBus;
      3'd6:    branch_addr = USEQUENCER_JumpAddr_InBus;
      3'd7:    branch_addr = DATAWIDTH_MADDR'({1'b1, USEQUENCER_DecodeOP_InBus, 2'b00});
      default: branch_addr = addr_inc;
    endcase
  end

`ifdef USEQUENCER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          timeout, timeout_nxt;
`endif

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
`ifdef USEQUENCER_TIMEOUT_EN
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      ST_RUN: begin
        if (stall) begin
          state_nxt = ST_WAIT;
`ifdef USEQUENCER_TIMEOUT_EN
          cnt_nxt = '0;
`endif
        end else begin
          addr_nxt = branch_addr;
        end
      end
      ST_WAIT: begin
        // ACK wins over a simultaneous expiry
        if (USEQUENCER_ACK_In) begin
          addr_nxt  = branch_addr;
          state_nxt = ST_RUN;
        end
`ifdef USEQUENCER_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          addr_nxt    = TRAP_ADDR;
          state_nxt   = ST_RUN;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge USEQUENCER_CLOCK_50 or negedge USEQUENCER_ResetInLow_In) begin
    if (!USEQUENCER_ResetInLow_In) begin
      state <= ST_RUN;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

`ifdef USEQUENCER_TIMEOUT_EN
  always_ff @(posedge USEQUENCER_CLOCK_50 or negedge USEQUENCER_ResetInLow_In) begin
    if (!USEQUENCER_ResetInLow_In) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
    end
  end
  assign USEQUENCER_Timeout_Out = timeout;
`else
  logic unused_cfg;
  assign unused_cfg             = ^{TRAP_ADDR, TIMEOUT_CYCLES[0]};
  assign USEQUENCER_Timeout_Out = 1'b0;
`endif

  assign USEQUENCER_MicroAddr_OutBus = addr;
  assign USEQUENCER_Waiting_Out      = (state == ST_WAIT);
  assign USEQUENCER_Hold_Out         = USEQUENCER_ResetInLow_In & stall;

endmodule
